// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves MEM loads/stores and IF fetches over one
// registered 8-bit synchronous RAM port, one byte per cycle, data before fetch.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [31:0]       mem_a_in,
    input  logic [31:0]       mem_d_in,
    input  logic [2:0]        mem_l_in,
    input  logic [1:0]        mem_wr_in,
    output logic [31:0]       mem_d_out,
    output logic              mem_en_out,
    output logic              stall_out,
    input  logic [31:0]       if_a_in,
    input  logic              if_req_in,
    output logic [31:0]       if_d_out,
    output logic              if_en_out,
    output logic [ADDR_W-1:0] ram_a_out,
    output logic [7:0]        ram_d_out,
    input  logic [7:0]        ram_d_in,
    output logic              ram_wr_out
);

    typedef enum logic [2:0] {IDLE, DRD, DWR, IRD, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        n;
    logic [1:0]        idx;
    logic [1:0]        idx_nxt;
    logic              is_fetch;
    logic [31:0]       wdata;
    logic [31:0]       rbuf;
    logic [31:0]       rbuf_nxt;
    logic              last;
    logic              data_ld;
    logic              data_st;
    logic              unused_bits;

    function automatic logic [2:0] len_dec(input logic [2:0] l);
        case (l)
            3'd1:    len_dec = 3'd1;
            3'd2:    len_dec = 3'd2;
            default: len_dec = 3'd4;
        endcase
    endfunction

    assign data_ld  = (mem_wr_in == 2'b01);
    assign data_st  = (mem_wr_in == 2'b10);
    assign idx_nxt  = idx + 2'd1;
    assign last     = ({1'b0, idx} == (n - 3'd1));
    assign rbuf_nxt = {ram_d_in, rbuf[31:8]};

    assign mem_en_out = (state == DONE) && !is_fetch;
    assign if_en_out  = (state == DONE) && is_fetch;
    assign stall_out  = (data_ld || data_st) && !mem_en_out;

    assign unused_bits = ^{mem_a_in[31:ADDR_W], if_a_in[31:ADDR_W], rbuf[7:0]};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (data_ld) begin
                    state_nxt = DRD;
                end else if (data_st) begin
                    state_nxt = DWR;
                end else if (if_req_in) begin
                    state_nxt = IRD;
                end
            end
            DRD, DWR, IRD: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM port is registered: the address for byte k is issued on edge T(k),
    // and the byte returned for it is captured on edge T(k+1).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr       <= '0;
            n          <= '0;
            idx        <= '0;
            is_fetch   <= 1'b0;
            wdata      <= '0;
            rbuf       <= '0;
            mem_d_out  <= '0;
            if_d_out   <= '0;
            ram_a_out  <= '0;
            ram_d_out  <= '0;
            ram_wr_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_ld || data_st) begin
                        addr       <= mem_a_in[ADDR_W-1:0];
                        n          <= len_dec(mem_l_in);
                        idx        <= '0;
                        is_fetch   <= 1'b0;
                        wdata      <= mem_d_in;
                        rbuf       <= '0;
                        ram_a_out  <= mem_a_in[ADDR_W-1:0];
                        ram_d_out  <= mem_d_in[7:0];
                        ram_wr_out <= data_st;
                    end else if (if_req_in) begin
                        addr       <= if_a_in[ADDR_W-1:0];
                        n          <= 3'd4;
                        idx        <= '0;
                        is_fetch   <= 1'b1;
                        rbuf       <= '0;
                        ram_a_out  <= if_a_in[ADDR_W-1:0];
                        ram_wr_out <= 1'b0;
                    end
                end
                DRD, IRD: begin
                    rbuf <= rbuf_nxt;
                    if (last) begin
                        if (state == IRD) begin
                            if_d_out <= rbuf_nxt;
                        end else begin
                            mem_d_out <= rbuf_nxt;
                        end
                    end else begin
                        idx       <= idx_nxt;
                        ram_a_out <= addr + ADDR_W'(idx_nxt);
                    end
                end
                DWR: begin
                    if (last) begin
                        ram_wr_out <= 1'b0;
                    end else begin
                        idx       <= idx_nxt;
                        ram_a_out <= addr + ADDR_W'(idx_nxt);
                        ram_d_out <= wdata[{idx_nxt, 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected completions and RAM
// writes into queues; a negedge monitor pops and compares as the DUT reports them.
module tb_mem_ctrl;

    logic        clk_in;
    logic        rst_in;
    logic [31:0] mem_a_in;
    logic [31:0] mem_d_in;
    logic [2:0]  mem_l_in;
    logic [1:0]  mem_wr_in;
    logic [31:0] mem_d_out;
    logic        mem_en_out;
    logic        stall_out;
    logic [31:0] if_a_in;
    logic        if_req_in;
    logic [31:0] if_d_out;
    logic        if_en_out;
    logic [16:0] ram_a_out;
    logic [7:0]  ram_d_out;
    logic [7:0]  ram_d_in;
    logic        ram_wr_out;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_mem[$];
    logic [31:0] exp_if[$];
    logic [24:0] exp_wr[$];

    logic [7:0] ram [0:131071];

    mem_ctrl #(.ADDR_W(17)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .mem_a_in  (mem_a_in),
        .mem_d_in  (mem_d_in),
        .mem_l_in  (mem_l_in),
        .mem_wr_in (mem_wr_in),
        .mem_d_out (mem_d_out),
        .mem_en_out(mem_en_out),
        .stall_out (stall_out),
        .if_a_in   (if_a_in),
        .if_req_in (if_req_in),
        .if_d_out  (if_d_out),
        .if_en_out (if_en_out),
        .ram_a_out (ram_a_out),
        .ram_d_out (ram_d_out),
        .ram_d_in  (ram_d_in),
        .ram_wr_out(ram_wr_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Read data for the registered address is available at the next edge.
    assign ram_d_in = ram[ram_a_out];

    always @(posedge clk_in) begin
        if (ram_wr_out) ram[ram_a_out] = ram_d_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (mem_en_out) begin
                if (exp_mem.size() == 0) fail_now("mem_en_out");
                else check("mem_d_out", mem_d_out, exp_mem.pop_front());
            end
            if (if_en_out) begin
                if (exp_if.size() == 0) fail_now("if_en_out");
                else check("if_d_out", if_d_out, exp_if.pop_front());
            end
            if (ram_wr_out) begin
                if (exp_wr.size() == 0) fail_now("ram_wr_out");
                else check("ram_write", {7'd0, ram_a_out, ram_d_out}, {7'd0, exp_wr.pop_front()});
            end
        end
    end

    // Issues one data request while idle and holds it until completion. n is
    // the expected byte count; completion is expected at negedge n+1 after accept.
    task automatic mem_txn(input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] l, input int n, input string tag);
        logic [16:0] seen [4];
        int          lat;
        bit          stall_bad;
        lat = 0;
        stall_bad = 1'b0;
        @(negedge clk_in);
        mem_wr_in = wr;
        mem_a_in  = a;
        mem_d_in  = d;
        mem_l_in  = l;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk_in);
            if (i <= 4) seen[i-1] = ram_a_out;
            if (mem_en_out) begin
                lat = i;
                check({tag, "_stall_at_done"}, {31'd0, stall_out}, 32'd0);
                mem_wr_in = 2'b00;
            end else if (!stall_out) begin
                stall_bad = 1'b1;
            end
        end
        mem_wr_in = 2'b00;
        check({tag, "_latency"}, lat, n + 1);
        check({tag, "_stall_while_busy"}, {31'd0, stall_bad}, 32'd0);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_addr%0d", tag, k), {15'd0, seen[k]}, {15'd0, 17'(a + 32'(k))});
        end
    endtask

    initial begin
        int mi;
        int fi;
        bit stall_bad;

        rst_in    = 1'b1;
        mem_a_in  = '0;
        mem_d_in  = '0;
        mem_l_in  = '0;
        mem_wr_in = '0;
        if_a_in   = '0;
        if_req_in = 1'b0;
        for (int i = 0; i < 131072; i++) ram[i] = 8'(i) ^ 8'h5A;
        ram[17'h104] = 8'h11; ram[17'h105] = 8'h22; ram[17'h106] = 8'h33; ram[17'h107] = 8'h44;
        ram[17'h010] = 8'h80;
        ram[17'h022] = 8'h77;
        ram[17'h200] = 8'h01; ram[17'h201] = 8'h02; ram[17'h202] = 8'h03; ram[17'h203] = 8'h04;
        ram[17'h000] = 8'hC3; ram[17'h001] = 8'hD4; ram[17'h002] = 8'hE5; ram[17'h003] = 8'hF6;
        ram[17'h1FFFE] = 8'hA1; ram[17'h1FFFF] = 8'hB2;
        ram[17'h302] = 8'h66; ram[17'h303] = 8'h99;

        repeat (3) @(negedge clk_in);
        check("rst_mem_d_out", mem_d_out, 32'd0);
        check("rst_if_d_out", if_d_out, 32'd0);
        check("rst_mem_en", {31'd0, mem_en_out}, 32'd0);
        check("rst_if_en", {31'd0, if_en_out}, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr_out}, 32'd0);
        check("rst_ram_a", {15'd0, ram_a_out}, 32'd0);
        check("rst_ram_d", {24'd0, ram_d_out}, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        exp_mem.push_back(32'h44332211);
        mem_txn(2'b01, 32'h104, 32'd0, 3'd4, 4, "lw");
        exp_mem.push_back(32'h80000000);
        mem_txn(2'b01, 32'h10, 32'd0, 3'd1, 1, "lb");
        exp_mem.push_back(32'h22110000);
        mem_txn(2'b01, 32'h104, 32'd0, 3'd2, 2, "lh");
        exp_mem.push_back(32'h44332211);
        mem_txn(2'b01, 32'h104, 32'd0, 3'd3, 4, "lw_len3");

        // Stores leave the load result register unchanged.
        exp_mem.push_back(32'h44332211);
        exp_wr.push_back({17'h020, 8'hEF});
        exp_wr.push_back({17'h021, 8'hBE});
        mem_txn(2'b10, 32'h20, 32'hDEADBEEF, 3'd2, 2, "sh");
        check("sh_ram20", {24'd0, ram[17'h020]}, 32'hEF);
        check("sh_ram21", {24'd0, ram[17'h021]}, 32'hBE);
        check("sh_ram22_untouched", {24'd0, ram[17'h022]}, 32'h77);
        check("sh_wr_low_after", {31'd0, ram_wr_out}, 32'd0);

        exp_mem.push_back(32'h44332211);
        exp_wr.push_back({17'h040, 8'hA5});
        mem_txn(2'b10, 32'h40, 32'h123456A5, 3'd1, 1, "sb");

        @(negedge clk_in);
        mem_wr_in = 2'b11;
        mem_a_in  = 32'h50;
        stall_bad = 1'b0;
        repeat (4) begin
            @(negedge clk_in);
            if (stall_out) stall_bad = 1'b1;
        end
        mem_wr_in = 2'b00;
        check("wr11_no_stall", {31'd0, stall_bad}, 32'd0);

        exp_mem.push_back(32'h04030201);
        exp_if.push_back(32'hF6E5D4C3);
        @(negedge clk_in);
        mem_wr_in = 2'b01; mem_a_in = 32'h200; mem_l_in = 3'd4;
        if_req_in = 1'b1;  if_a_in = 32'h0;
        mi = 0; fi = 0;
        for (int i = 1; i <= 30 && fi == 0; i++) begin
            @(negedge clk_in);
            if (mem_en_out && mi == 0) begin mi = i; mem_wr_in = 2'b00; end
            if (if_en_out) begin fi = i; if_req_in = 1'b0; end
        end
        mem_wr_in = 2'b00; if_req_in = 1'b0;
        check("prio_mem_cycle", mi, 32'd5);
        check("prio_if_cycle", fi, 32'd11);

        exp_if.push_back(32'h44332211);
        exp_mem.push_back(32'h80000000);
        @(negedge clk_in);
        if_req_in = 1'b1; if_a_in = 32'h104;
        @(negedge clk_in);
        mem_wr_in = 2'b01; mem_a_in = 32'h10; mem_l_in = 3'd1;
        @(negedge clk_in);
        check("fetch_blocks_stall", {31'd0, stall_out}, 32'd1);
        mi = 0; fi = 0;
        for (int i = 3; i <= 30 && mi == 0; i++) begin
            @(negedge clk_in);
            if (if_en_out) begin fi = i; if_req_in = 1'b0; end
            if (mem_en_out) begin mi = i; mem_wr_in = 2'b00; end
        end
        mem_wr_in = 2'b00; if_req_in = 1'b0;
        check("fetch_first_cycle", fi, 32'd5);
        check("data_after_fetch_cycle", mi, 32'd8);

        exp_mem.push_back(32'hD4C3B2A1);
        mem_txn(2'b01, 32'h1FFFE, 32'd0, 3'd4, 4, "wrap");

        exp_wr.push_back({17'h300, 8'hD4});
        exp_wr.push_back({17'h301, 8'hC3});
        @(negedge clk_in);
        mem_wr_in = 2'b10; mem_a_in = 32'h300; mem_d_in = 32'hA1B2C3D4; mem_l_in = 3'd4;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b1;
        #1 check("rst_mid_ram_wr", {31'd0, ram_wr_out}, 32'd0);
        mem_wr_in = 2'b00;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_mid_ram300", {24'd0, ram[17'h300]}, 32'hD4);
        check("rst_mid_ram301", {24'd0, ram[17'h301]}, 32'hC3);
        check("rst_mid_ram302", {24'd0, ram[17'h302]}, 32'h66);
        check("rst_mid_ram303", {24'd0, ram[17'h303]}, 32'h99);

        exp_mem.push_back(32'h80000000);
        mem_txn(2'b01, 32'h10, 32'd0, 3'd1, 1, "lb_after_rst");

        repeat (3) @(negedge clk_in);
        check("exp_mem_drained", exp_mem.size(), 32'd0);
        check("exp_if_drained", exp_if.size(), 32'd0);
        check("exp_wr_drained", exp_wr.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller directly downstream of the MEM stage.
- Accepts word, halfword and byte load/store requests from MEM, and 4-byte instruction fetches from IF.
- Drives a single synchronous 8-bit RAM port, one byte per cycle.
- Returns assembled data and a one-cycle completion strobe to the requester.

Parameters:
ADDR_W, 17, width of RAM byte address; request addresses truncated to low ADDR_W bits.

Ports:
clk_in  input  1  system clock, rising edge
rst_in  input  1  reset, asynchronous, active-high
mem_a_in  input  32  data request byte address (from MEM)
mem_d_in  input  32  store data; byte k = bits [8k+7:8k]
mem_l_in  input  3  access length in bytes: 1, 2 or 4
mem_wr_in  input  2  00 none, 01 load, 10 store, 11 treated as none
mem_d_out  output  32  load result, left-justified (see Behaviour)
mem_en_out  output  1  data request complete, one-cycle pulse
stall_out  output  1  data request pending and not completing this cycle
if_a_in  input  32  instruction fetch address
if_req_in  input  1  fetch request, level
if_d_out  output  32  fetched instruction word, little-endian
if_en_out  output  1  fetch complete, one-cycle pulse
ram_a_out  output  ADDR_W  RAM byte address
ram_d_out  output  8  RAM write data
ram_d_in  input  8  RAM read data, valid one cycle after address presented
ram_wr_out  output  1  1 write, 0 read

Behaviour:
- Reset state:
  - state IDLE, all outputs 0; RAM outputs registered, so ram_wr_out is 0 immediately on reset.
  - Reset mid-transaction abandons it: no en pulse, no further RAM writes.
- States: IDLE, DRD (data read), DWR (data write), IRD (instruction read), DONE.
- Length decode: n = 1 for l=1, 2 for l=2, 4 for any other value.
- IDLE, at clock edge T0:
  - If mem_wr_in=01: latch addr, n, kind → DRD.
  - Else if mem_wr_in=10: latch addr, n, store data → DWR.
  - Else if if_req_in: latch if_a_in, n=4 → IRD.
  - Data always has priority over fetch. Latched values are used for the rest of the transaction; input changes are ignored.
  - Read assembly buffer cleared at T0.
- Address generation: byte k driven as ram_a_out = (addr + k)[ADDR_W-1:0], k = 0..n-1, one per cycle after edges T0..T(n-1). Wraps modulo 2^ADDR_W.
- DRD / IRD:
  - ram_wr_out=0.
  - Byte k captured at edge T(k+1), i.e. the edge after RAM samples the address.
  - Capture rule: buf ← {ram_d_in, buf[31:8]}.
  - After n bytes the data occupies the top n bytes, lower bits 0:
    - LB: [31:24] = byte(a).
    - LH: [31:16] = {byte(a+1), byte(a)}.
    - LW / fetch: {b3, b2, b1, b0}.
  - At the final capture edge T(n), load mem_d_out (DRD) or if_d_out (IRD) with the final value → DONE.
- DWR:
  - ram_wr_out=1, ram_d_out = store byte k, in the cycle after T(k).
  - At T(n), ram_wr_out ← 0 → DONE.
  - Exactly n bytes written.
- DONE (one cycle):
  - mem_en_out=1 or if_en_out=1 according to the transaction kind.
  - Requests are ignored in this cycle; the requester still shows the old request here.
  - → IDLE. Next acceptance is no earlier than the edge ending the following IDLE cycle.
- Completion timing after accept: read completes n+1 cycles after T0 (en high in cycle after T(n)); write likewise.
- Data output registers hold their value until the next completion of the same kind.
- stall_out (combinational): (mem_wr_in==01 or 10) and not mem_en_out. It is high while a fetch blocks a data request.
- A fetch in progress is never preempted; a data request arriving meanwhile waits.
- mem_wr_in=11 is ignored.

Test Plan:
- LW at 0x104, RAM[0x104..0x107] = 11,22,33,44 → ram_a_out 0x104..0x107 on consecutive cycles, ram_wr_out=0 throughout; mem_d_out=0x44332211, mem_en_out single pulse 5 cycles after accept; stall_out high until that cycle.
- LB at 0x10, RAM=0x80 → one RAM address issued; mem_d_out=0x80000000, en 2 cycles after accept.
- SH at 0x20, data 0xDEADBEEF → writes 0xEF@0x20 then 0xBE@0x21; ram_wr_out low afterwards; RAM[0x22] untouched; mem_en_out pulses once.
- LW at 0x200 and fetch at 0x000 raised in the same cycle → data completes first; after DONE+IDLE the fetch runs; if_d_out = little-endian word at 0x000, if_en_out one pulse.
- rst_in asserted after 2 bytes of a SW → ram_wr_out 0 immediately, no en pulse, only 2 bytes modified; a subsequent LB completes normally.
- LW at 0x1FFFE with ADDR_W=17 → addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001; data assembled in that order.
